fetch_unit: RTL and testbench

Parametrised instruction fetch stage with a decoupling prefetch queue. It holds the fetch PC and issues one word request per cycle to a synchronous instruction memory. Responses are buffered together with their PC and PC+4, and the queue drains to decode through a valid/ready handshake. Redirects from execute flush all younger state, and a misaligned redirect target halts fetch with an error flag.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by fetch_fifo and fetch_unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH,
    IDLE,
    HALT
  } fetch_state_e;

  localparam int unsigned PC_STEP   = 4;
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of fetch entries.
// Flush wins over push; pop on empty is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         Clk_Core,
  input  logic         Rst_Core,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [CW-1:0] count,
  output fetch_entry_t head,
  output logic         empty
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge Clk_Core) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, one-cycle imem,
// prefetch queue toward decode, redirect flush and halt.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int             FIFO_DEPTH   = 4
) (
  input  logic            Clk_Core,
  input  logic            Rst_Core,
  input  logic            Run,
  input  logic            Redirect_Valid,
  input  logic [XLEN-1:0] Redirect_Target,
  output logic            Imem_Req,
  output logic [XLEN-1:0] Imem_Addr,
  input  logic [31:0]     Imem_Rdata,
  output logic            Dec_Valid,
  input  logic            Dec_Ready,
  output logic [31:0]     Dec_Instruction,
  output logic [XLEN-1:0] Dec_Program_Count,
  output logic [XLEN-1:0] Dec_Program_Count_Plus,
  output logic            Misaligned_Err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic            inflight;
  logic            err_q;
  logic [CW-1:0]   count;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            empty;
  logic            pop;
  logic            misaligned;
  logic [CW:0]     used;
  logic            credit_ok;

  assign misaligned = Redirect_Valid & (|Redirect_Target[1:0]);
  assign pop        = Dec_Valid & Dec_Ready;

  // Slots already claimed: queued + in flight, minus one leaving now.
  assign used = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign credit_ok = (used < (CW+1)'(FIFO_DEPTH));

  assign Imem_Req = ~Rst_Core & (state_q == FETCH) & Run
                  & ~Redirect_Valid & credit_ok;
  assign Imem_Addr = fetch_pc;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (!Run) state_d = IDLE;
      IDLE:    if (Run)  state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
    if (misaligned) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge Clk_Core) begin
    if (Rst_Core) begin
      state_q  <= FETCH;
      fetch_pc <= RESET_VECTOR;
      resp_pc  <= '0;
      inflight <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      inflight <= Imem_Req;
      if (Redirect_Valid && !misaligned) begin
        fetch_pc <= Redirect_Target;
      end else if (Imem_Req) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end
      if (Imem_Req) begin
        resp_pc <= fetch_pc;
      end
      if (misaligned) begin
        err_q <= 1'b1;
      end
    end
  end

  assign push_data.instr   = Imem_Rdata;
  assign push_data.pc      = 32'(resp_pc);
  assign push_data.pc_plus = 32'(resp_pc + XLEN'(PC_STEP));

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .Clk_Core (Clk_Core),
    .Rst_Core (Rst_Core),
    .push     (inflight),
    .pop      (pop),
    .flush    (Redirect_Valid),
    .push_data(push_data),
    .count    (count),
    .head     (head),
    .empty    (empty)
  );

  assign Dec_Valid = ~empty;
  assign Dec_Instruction = empty ? INSTR_NOP : head.instr;
  assign Dec_Program_Count = empty ? '0 : XLEN'(head.pc);
  assign Dec_Program_Count_Plus = empty ? '0 : XLEN'(head.pc_plus);
  assign Misaligned_Err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, scoreboard
// model of the fetch queue, and directed corner sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0100;

  logic        Clk_Core = 1'b0;
  logic        Rst_Core = 1'b1;
  logic        Run = 1'b0;
  logic        Redirect_Valid = 1'b0;
  logic [31:0] Redirect_Target = '0;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic [31:0] Imem_Rdata = '0;
  logic        Dec_Valid;
  logic        Dec_Ready = 1'b0;
  logic [31:0] Dec_Instruction;
  logic [31:0] Dec_Program_Count;
  logic [31:0] Dec_Program_Count_Plus;
  logic        Misaligned_Err;

  fetch_unit #(
    .XLEN(32),
    .RESET_VECTOR(RV),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .Clk_Core              (Clk_Core),
    .Rst_Core              (Rst_Core),
    .Run                   (Run),
    .Redirect_Valid        (Redirect_Valid),
    .Redirect_Target       (Redirect_Target),
    .Imem_Req              (Imem_Req),
    .Imem_Addr             (Imem_Addr),
    .Imem_Rdata            (Imem_Rdata),
    .Dec_Valid             (Dec_Valid),
    .Dec_Ready             (Dec_Ready),
    .Dec_Instruction       (Dec_Instruction),
    .Dec_Program_Count     (Dec_Program_Count),
    .Dec_Program_Count_Plus(Dec_Program_Count_Plus),
    .Misaligned_Err        (Misaligned_Err)
  );

  always #5 Clk_Core = ~Clk_Core;

  function automatic logic [31:0] instr_of(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  always @(posedge Clk_Core) begin
    Imem_Rdata <= Imem_Req ? instr_of(Imem_Addr) : 32'hDEAD_BEEF;
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", n, act, exp);
  endtask

  // Scoreboard: queued entries followed by the in-flight one.
  fetch_entry_t mq[$];
  bit           m_infl;
  fetch_state_e mst;
  logic [31:0]  mpc;
  bit           merr;

  bit          s_req;
  bit          s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_plus;

  task automatic model_reset();
    mq.delete();
    m_infl = 0;
    mst    = FETCH;
    mpc    = RV;
    merr   = 0;
  endtask

  task automatic do_reset();
    @(posedge Clk_Core); #1;
    Rst_Core = 1; Run = 0; Dec_Ready = 0; Redirect_Valid = 0;
    @(posedge Clk_Core); #1;
    @(negedge Clk_Core);
    chk("rst_valid", 32'(Dec_Valid), 0);
    chk("rst_req", 32'(Imem_Req), 0);
    chk("rst_err", 32'(Misaligned_Err), 0);
    chk("rst_pc", Dec_Program_Count, 0);
    chk("rst_plus", Dec_Program_Count_Plus, 0);
    model_reset();
  endtask

  task automatic cycle(input bit run, input bit rdy,
                       input bit rv, input logic [31:0] tgt);
    int          queued;
    bit          ev;
    bit          pop;
    bit          er;
    bit          mis;
    fetch_entry_t e;
    @(posedge Clk_Core); #1;
    Rst_Core = 0; Run = run; Dec_Ready = rdy;
    Redirect_Valid = rv; Redirect_Target = tgt;
    @(negedge Clk_Core);
    s_req = Imem_Req; s_valid = Dec_Valid; s_addr = Imem_Addr;
    s_pc = Dec_Program_Count; s_plus = Dec_Program_Count_Plus;
    queued = mq.size() - int'(m_infl);
    ev  = queued > 0;
    pop = ev & rdy;
    er  = (mst == FETCH) & run & ~rv
        & ((mq.size() - int'(pop)) < DEPTH);
    chk("dec_valid", 32'(Dec_Valid), 32'(ev));
    if (ev) begin
      chk("dec_pc", Dec_Program_Count, mq[0].pc);
      chk("dec_plus", Dec_Program_Count_Plus, mq[0].pc_plus);
      chk("dec_instr", Dec_Instruction, mq[0].instr);
    end
    chk("imem_req", 32'(Imem_Req), 32'(er));
    if (er) chk("imem_addr", Imem_Addr, mpc);
    chk("mis_err", 32'(Misaligned_Err), 32'(merr));
    mis = rv & (tgt[1:0] != 2'b00);
    if (rv) begin
      mq.delete();
      m_infl = 0;
      if (!mis) mpc = tgt;
    end else begin
      if (pop) void'(mq.pop_front());
      m_infl = 0;
      if (er) begin
        e.instr = instr_of(mpc);
        e.pc = mpc;
        e.pc_plus = mpc + 32'd4;
        mq.push_back(e);
        m_infl = 1;
        mpc = mpc + 32'd4;
      end
    end
    if (mst == FETCH && !run) mst = IDLE;
    else if (mst == IDLE && run) mst = FETCH;
    if (mis) begin
      mst = HALT;
      merr = 1;
    end
  endtask

  typedef struct {
    bit          run;
    bit          rdy;
    bit          rv;
    logic [31:0] tgt;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int  n;
    bit  seen;
    tbl[0] = '{1, 1, 0, 32'h0,   1, 32'h100, 0, 32'h0};
    tbl[1] = '{1, 1, 0, 32'h0,   1, 32'h104, 0, 32'h0};
    tbl[2] = '{1, 1, 0, 32'h0,   1, 32'h108, 1, 32'h100};
    tbl[3] = '{1, 1, 0, 32'h0,   1, 32'h10C, 1, 32'h104};
    tbl[4] = '{1, 1, 1, 32'h200, 0, 32'h0,   1, 32'h108};
    tbl[5] = '{1, 1, 0, 32'h0,   1, 32'h200, 0, 32'h0};
    tbl[6] = '{1, 1, 0, 32'h0,   1, 32'h204, 0, 32'h0};
    tbl[7] = '{1, 1, 0, 32'h0,   1, 32'h208, 1, 32'h200};

    do_reset();
    foreach (tbl[i]) begin
      cycle(tbl[i].run, tbl[i].rdy, tbl[i].rv, tbl[i].tgt);
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      if (tbl[i].e_req)
        chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid),
          32'(tbl[i].e_valid));
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end

    // Decode stalls: queue fills, requests stop.
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    chk("stall_req", 32'(s_req), 0);
    chk("stall_valid", 32'(s_valid), 1);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);

    // Full queue plus one in flight, then redirect.
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 0, 1, 32'h300);
    n = 0;
    seen = 0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cycle(1, 1, 0, 0);
      n++;
      if (s_valid) seen = 1;
    end
    chk("redir_seen", 32'(seen), 1);
    chk("redir_pc", s_pc, 32'h300);
    chk("redir_lat", 32'(n), 3);

    // Run low mid-stream.
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);

    // Address wrap.
    cycle(1, 1, 1, 32'hFFFF_FFF8);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1, 1, 0, 0);
      if (s_valid && s_pc == 32'hFFFF_FFFC) begin
        seen = 1;
        chk("wrap_plus", s_plus, 32'h0);
      end
    end
    chk("wrap_seen", 32'(seen), 1);

    // Misaligned redirect halts until reset.
    cycle(1, 1, 1, 32'h202);
    cycle(1, 1, 0, 0);
    chk("mis_rise", 32'(Misaligned_Err), 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
    chk("halt_req", 32'(s_req), 0);
    chk("halt_valid", 32'(s_valid), 0);

    do_reset();
    cycle(1, 1, 0, 0);
    chk("restart_req", 32'(s_req), 1);
    chk("restart_addr", s_addr, RV);
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);

    // Reset mid-stream with a request in flight.
    cycle(1, 0, 0, 0);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
